// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared state encoding and default geometry for the cache fill engine
package cache_fill_pkg;
  typedef enum logic {IDLE, FILL} state_t;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_TIMEOUT_CYCLES = 32;
  localparam int WORD_IDX_BITS = $clog2(DEF_WORDS_PER_BLOCK);
  localparam int BLOCK_OFFSET_BITS = WORD_IDX_BITS + 1;
  localparam int TIMEOUT_CNT_BITS = $clog2(DEF_TIMEOUT_CYCLES + 1);
endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// fill_counter: up-counter with synchronous clear/enable and a terminal-count flag at LIMIT
module fill_counter #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  always_ff @(posedge clk)
    count <= (rst || clr) ? '0 : en ? count + 1'b1 : count;
  assign tc = count == WIDTH'(LIMIT);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: block fill engine for cache misses; FILL_TIMEOUT_EN adds a watchdog abort
module cache_fill_fsm
  import cache_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  output logic                               memory_enable,
  output logic [ADDR_WIDTH-1:0]              memory_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data,
  output logic                               fsm_busy,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_index,
  output logic [15:0]                        cache_write_data,
  output logic                               write_tag_array,
  output logic                               fill_error
);
  localparam int IW = $clog2(WORDS_PER_BLOCK);
  localparam int OW = IW + 1;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] base;
  logic [IW:0] issue_cnt;
  logic [IW-1:0] recv_cnt;
  logic issue_tc, recv_tc, fill, recv, last, done, timeout, clr;
  assign fill = state_q == FILL;
  assign recv = fill && memory_data_valid;
  assign last = recv && recv_tc;
  assign done = last || timeout;
  assign clr = !fill || done;
  fill_counter #(.WIDTH(IW + 1), .LIMIT(WORDS_PER_BLOCK)) u_issue (
    .clk(clk), .rst(rst), .clr(clr), .en(memory_enable), .count(issue_cnt), .tc(issue_tc)
  );
  fill_counter #(.WIDTH(IW), .LIMIT(WORDS_PER_BLOCK - 1)) u_recv (
    .clk(clk), .rst(rst), .clr(clr), .en(recv), .count(recv_cnt), .tc(recv_tc)
  );
`ifdef FILL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic wd_tc;
  fill_counter #(.WIDTH(TW), .LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk(clk), .rst(rst), .clr(clr || memory_data_valid), .en(fill), .count(wd_cnt), .tc(wd_tc)
  );
  assign timeout = fill && wd_tc && !memory_data_valid;
`else
  assign timeout = 1'b0;
`endif
  assign fill_error = timeout;
  always_comb
    state_d = fill ? (done ? IDLE : FILL) : (miss_detected ? FILL : IDLE);
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    base <= rst ? '0 : (!fill && miss_detected) ? miss_address & ~ADDR_WIDTH'((1 << OW) - 1) : base;
  end
  assign memory_enable = fill && !issue_tc;
  assign memory_address = memory_enable ? base | ADDR_WIDTH'({issue_cnt, 1'b0}) : '0;
  assign fsm_busy = fill;
  assign write_data_array = recv;
  assign cache_word_index = recv ? recv_cnt : '0;
  assign cache_write_data = memory_data;
  assign write_tag_array = last;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed vector table plus hand sequences for reset abort and watchdog
module tb_cache_fill_fsm;
  logic clk = 0, rst = 1, miss_detected = 0, memory_data_valid = 0;
  logic [15:0] miss_address = 0, memory_data = 0, memory_address, cache_write_data;
  logic memory_enable, fsm_busy, write_data_array, write_tag_array, fill_error;
  logic [2:0] cache_word_index;
  int nvec = 0, nbad = 0;
  typedef struct {
    logic m; logic [15:0] a; logic v; logic [15:0] d;
    logic en; logic [15:0] ma; logic bz; logic wd; logic [2:0] ix; logic tg;
  } vec_t;
  vec_t tbl[$];
  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_enable(memory_enable), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data), .fsm_busy(fsm_busy),
    .write_data_array(write_data_array), .cache_word_index(cache_word_index),
    .cache_write_data(cache_write_data), .write_tag_array(write_tag_array), .fill_error(fill_error)
  );
  always #5 clk = ~clk;
  function automatic void add(logic m, logic [15:0] a, logic v, logic [15:0] d, logic en,
                              logic [15:0] ma, logic bz, logic wd, logic [2:0] ix, logic tg);
    tbl.push_back('{m, a, v, d, en, ma, bz, wd, ix, tg});
  endfunction
  task automatic drive(input logic r, input logic m, input logic [15:0] a, input logic v, input logic [15:0] d);
    @(negedge clk);
    rst = r;
    miss_detected = m;
    miss_address = a;
    memory_data_valid = v;
    memory_data = d;
    #2;
  endtask
  task automatic chk(input string nm, input logic en, input logic [15:0] ma, input logic bz,
                     input logic wd, input logic [2:0] ix, input logic tg, input logic er);
    nvec++;
    if ({memory_enable, memory_address, fsm_busy, write_data_array, cache_word_index, write_tag_array, fill_error, cache_write_data}
        !== {en, ma, bz, wd, ix, tg, er, memory_data}) begin
      nbad++;
      $display("FAIL %s: got en=%b addr=%h busy=%b wda=%b idx=%0d tag=%b err=%b wdata=%h, want en=%b addr=%h busy=%b wda=%b idx=%0d tag=%b err=%b wdata=%h",
               nm, memory_enable, memory_address, fsm_busy, write_data_array, cache_word_index, write_tag_array,
               fill_error, cache_write_data, en, ma, bz, wd, ix, tg, er, memory_data);
    end
  endtask
  initial begin
    add(1, 'h1234, 0, 'h0000, 0, 'h0000, 0, 0, 0, 0);
    add(0, 'h1234, 0, 'h0000, 1, 'h1230, 1, 0, 0, 0);
    add(0, 'h1234, 0, 'h0000, 1, 'h1232, 1, 0, 0, 0);
    add(0, 'h1234, 0, 'h0000, 1, 'h1234, 1, 0, 0, 0);
    add(0, 'h1234, 0, 'h0000, 1, 'h1236, 1, 0, 0, 0);
    add(0, 'h1234, 1, 'hA000, 1, 'h1238, 1, 1, 0, 0);
    add(0, 'h1234, 1, 'hA001, 1, 'h123A, 1, 1, 1, 0);
    add(0, 'h1234, 1, 'hA002, 1, 'h123C, 1, 1, 2, 0);
    add(0, 'h1234, 1, 'hA003, 1, 'h123E, 1, 1, 3, 0);
    add(0, 'h1234, 1, 'hA004, 0, 'h0000, 1, 1, 4, 0);
    add(0, 'h1234, 1, 'hA005, 0, 'h0000, 1, 1, 5, 0);
    add(0, 'h1234, 1, 'hA006, 0, 'h0000, 1, 1, 6, 0);
    add(0, 'h1234, 1, 'hA007, 0, 'h0000, 1, 1, 7, 1);
    add(0, 'h1234, 1, 'hBEEF, 0, 'h0000, 0, 0, 0, 0);
    add(1, 'hFFFA, 0, 'h0000, 0, 'h0000, 0, 0, 0, 0);
    add(0, 'hFFFA, 0, 'h0000, 1, 'hFFF0, 1, 0, 0, 0);
    add(0, 'hFFFA, 0, 'h0000, 1, 'hFFF2, 1, 0, 0, 0);
    add(0, 'hFFFA, 1, 'hC000, 1, 'hFFF4, 1, 1, 0, 0);
    add(0, 'hFFFA, 1, 'hC001, 1, 'hFFF6, 1, 1, 1, 0);
    add(0, 'hFFFA, 1, 'hC002, 1, 'hFFF8, 1, 1, 2, 0);
    add(0, 'hFFFA, 0, 'h0000, 1, 'hFFFA, 1, 0, 0, 0);
    add(0, 'hFFFA, 0, 'h0000, 1, 'hFFFC, 1, 0, 0, 0);
    add(0, 'hFFFA, 1, 'hC003, 1, 'hFFFE, 1, 1, 3, 0);
    add(0, 'hFFFA, 1, 'hC004, 0, 'h0000, 1, 1, 4, 0);
    add(0, 'hFFFA, 1, 'hC005, 0, 'h0000, 1, 1, 5, 0);
    add(0, 'hFFFA, 0, 'h0000, 0, 'h0000, 1, 0, 0, 0);
    add(0, 'hFFFA, 0, 'h0000, 0, 'h0000, 1, 0, 0, 0);
    add(0, 'hFFFA, 1, 'hC006, 0, 'h0000, 1, 1, 6, 0);
    add(0, 'hFFFA, 1, 'hC007, 0, 'h0000, 1, 1, 7, 1);
    add(0, 'hFFFA, 0, 'h0000, 0, 'h0000, 0, 0, 0, 0);
    add(1, 'h1230, 0, 'h0000, 0, 'h0000, 0, 0, 0, 0);
    add(1, 'h4000, 0, 'h0000, 1, 'h1230, 1, 0, 0, 0);
    add(1, 'h4000, 1, 'hE000, 1, 'h1232, 1, 1, 0, 0);
    add(1, 'h4000, 1, 'hE001, 1, 'h1234, 1, 1, 1, 0);
    add(1, 'h4000, 1, 'hE002, 1, 'h1236, 1, 1, 2, 0);
    add(1, 'h4000, 1, 'hE003, 1, 'h1238, 1, 1, 3, 0);
    add(1, 'h4000, 1, 'hE004, 1, 'h123A, 1, 1, 4, 0);
    add(1, 'h4000, 1, 'hE005, 1, 'h123C, 1, 1, 5, 0);
    add(1, 'h4000, 1, 'hE006, 1, 'h123E, 1, 1, 6, 0);
    add(1, 'h4000, 1, 'hE007, 0, 'h0000, 1, 1, 7, 1);
    add(1, 'h4000, 0, 'h0000, 0, 'h0000, 0, 0, 0, 0);
    add(0, 'h4000, 0, 'h0000, 1, 'h4000, 1, 0, 0, 0);
    add(0, 'h4000, 0, 'h0000, 1, 'h4002, 1, 0, 0, 0);
    drive(1, 0, 'h0000, 0, 'h5A5A);
    chk("reset_state", 0, 'h0000, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(0, tbl[i].m, tbl[i].a, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].en, tbl[i].ma, tbl[i].bz, tbl[i].wd, tbl[i].ix, tbl[i].tg, 0);
    end
    drive(1, 0, 'h0000, 0, 'h0000);
    drive(0, 0, 'h0000, 0, 'h0000);
    chk("rst_clears_fill", 0, 'h0000, 0, 0, 0, 0, 0);
    drive(0, 1, 'h2000, 0, 'h0000);
    chk("rst_seq_c0", 0, 'h0000, 0, 0, 0, 0, 0);
    drive(0, 0, 'h2000, 0, 'h0000);
    chk("rst_seq_c1", 1, 'h2000, 1, 0, 0, 0, 0);
    drive(0, 0, 'h2000, 0, 'h0000);
    chk("rst_seq_c2", 1, 'h2002, 1, 0, 0, 0, 0);
    drive(0, 0, 'h2000, 1, 'h7000);
    chk("rst_seq_c3", 1, 'h2004, 1, 1, 0, 0, 0);
    drive(1, 0, 'h2000, 0, 'h0000);
    chk("rst_seq_c4", 1, 'h2006, 1, 0, 0, 0, 0);
    drive(0, 0, 'h2000, 1, 'h7001);
    chk("rst_seq_c5_idle", 0, 'h0000, 0, 0, 0, 0, 0);
    drive(0, 0, 'h2000, 1, 'h7002);
    chk("rst_seq_late_valid", 0, 'h0000, 0, 0, 0, 0, 0);
    drive(0, 1, 'h2000, 0, 'h0000);
    chk("rst_seq_new_miss", 0, 'h0000, 0, 0, 0, 0, 0);
    drive(0, 0, 'h2000, 1, 'h7100);
    chk("rst_seq_restart_w0", 1, 'h2000, 1, 1, 0, 0, 0);
    drive(0, 0, 'h2000, 1, 'h7101);
    chk("rst_seq_restart_w1", 1, 'h2002, 1, 1, 1, 0, 0);
    drive(1, 0, 'h0000, 0, 'h0000);
    drive(0, 1, 'h3000, 0, 'h0000);
    chk("wd_c0", 0, 'h0000, 0, 0, 0, 0, 0);
`ifdef FILL_TIMEOUT_EN
    for (int c = 1; c <= 34; c++) begin
      drive(0, 0, 'h3000, 0, 'h0000);
      if (c == 34) chk("wd_after_abort", 0, 'h0000, 0, 0, 0, 0, 0);
      else chk($sformatf("wd_c%0d", c), c <= 8, c <= 8 ? 16'h3000 + 16'(2 * (c - 1)) : 16'h0000, 1, 0, 0, 0, c == 33);
    end
`else
    for (int c = 1; c <= 40; c++) begin
      drive(0, 0, 'h3000, 0, 'h0000);
      chk($sformatf("nowd_c%0d", c), c <= 8, c <= 8 ? 16'h3000 + 16'(2 * (c - 1)) : 16'h0000, 1, 0, 0, 0, 0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
